// File: rtl/bp_clint_slice.sv
// Core-local interruptor for one hart: mipi, mtimecmp and mtime behind a
// single-outstanding command/response port, driving software and timer interrupts.
module bp_clint_slice #(
    parameter int paddr_width_p = 56,
    parameter int mtime_div_p   = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     cmd_v_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_w_i,
    input  logic [paddr_width_p-1:0] cmd_addr_i,
    input  logic [63:0]              cmd_data_i,
    output logic                     resp_v_o,
    input  logic                     resp_yumi_i,
    output logic [63:0]              resp_data_o,
    output logic                     resp_err_o,
    output logic                     software_irq_o,
    output logic                     timer_irq_o
);

    localparam logic [paddr_width_p-1:0] mipi_addr_lp     = paddr_width_p'(32'h0030_0000);
    localparam logic [paddr_width_p-1:0] mtimecmp_addr_lp = paddr_width_p'(32'h0030_4000);
    localparam logic [paddr_width_p-1:0] mtime_addr_lp    = paddr_width_p'(32'h0030_bff8);
    localparam logic [7:0]               presc_max_lp     = 8'(mtime_div_p - 1);

    typedef enum logic {
        eReady = 1'b0,
        eResp  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        resp_v_q, resp_v_d;
    logic [63:0] resp_data_q, resp_data_d;
    logic        resp_err_q, resp_err_d;
    logic        mipi_q, mipi_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [63:0] mtime_q, mtime_d;
    logic [7:0]  presc_q, presc_d;
    logic        sw_irq_q, sw_irq_d;
    logic        timer_irq_q, timer_irq_d;

    logic        accept;
    logic        wrap;
    logic        hit_mipi, hit_mtimecmp, hit_mtime, hit_any;
    logic [63:0] rdata;

    always_comb begin
        state_d     = state_q;
        resp_v_d    = resp_v_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        mipi_d      = mipi_q;
        mtimecmp_d  = mtimecmp_q;

        accept       = cmd_v_i && (state_q == eReady);
        hit_mipi     = (cmd_addr_i == mipi_addr_lp);
        hit_mtimecmp = (cmd_addr_i == mtimecmp_addr_lp);
        hit_mtime    = (cmd_addr_i == mtime_addr_lp);
        hit_any      = hit_mipi || hit_mtimecmp || hit_mtime;

        rdata = 64'd0;
        if (hit_mipi)     rdata = {63'd0, mipi_q};
        if (hit_mtimecmp) rdata = mtimecmp_q;
        if (hit_mtime)    rdata = mtime_q;

        wrap    = (presc_q == presc_max_lp);
        presc_d = wrap ? 8'd0 : presc_q + 8'd1;
        mtime_d = wrap ? mtime_q + 64'd1 : mtime_q;

        // Reads capture pre-increment state; an mtime write overrides a coincident tick.
        case (state_q)
            eReady: begin
                if (accept) begin
                    state_d     = eResp;
                    resp_v_d    = 1'b1;
                    resp_err_d  = !hit_any;
                    resp_data_d = (!cmd_w_i && hit_any) ? rdata : 64'd0;
                    if (cmd_w_i && hit_mipi)     mipi_d     = cmd_data_i[0];
                    if (cmd_w_i && hit_mtimecmp) mtimecmp_d = cmd_data_i;
                    if (cmd_w_i && hit_mtime)    mtime_d    = cmd_data_i;
                end
            end
            eResp: begin
                if (resp_yumi_i) begin
                    state_d     = eReady;
                    resp_v_d    = 1'b0;
                    resp_data_d = 64'd0;
                    resp_err_d  = 1'b0;
                end
            end
            default: state_d = eReady;
        endcase

        cmd_ready_d = (state_d == eReady);
        timer_irq_d = (mtime_d >= mtimecmp_d);
        sw_irq_d    = mipi_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= eReady;
            cmd_ready_q <= 1'b1;
            resp_v_q    <= 1'b0;
            resp_data_q <= 64'd0;
            resp_err_q  <= 1'b0;
            mipi_q      <= 1'b0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            mtime_q     <= 64'd0;
            presc_q     <= 8'd0;
            sw_irq_q    <= 1'b0;
            timer_irq_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            resp_v_q    <= resp_v_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            mipi_q      <= mipi_d;
            mtimecmp_q  <= mtimecmp_d;
            mtime_q     <= mtime_d;
            presc_q     <= presc_d;
            sw_irq_q    <= sw_irq_d;
            timer_irq_q <= timer_irq_d;
        end
    end

    assign cmd_ready_o    = cmd_ready_q;
    assign resp_v_o       = resp_v_q;
    assign resp_data_o    = resp_data_q;
    assign resp_err_o     = resp_err_q;
    assign software_irq_o = sw_irq_q;
    assign timer_irq_o    = timer_irq_q;

endmodule

// File: tb/tb_bp_clint_slice.sv
// Self-checking bench for bp_clint_slice: directed scenarios plus random traffic
// compared against a cycle-count based model of the clint registers.
module tb_bp_clint_slice;

    localparam int AW  = 56;
    localparam int DIV = 8;
    localparam logic [AW-1:0] A_MIPI  = 56'h30_0000;
    localparam logic [AW-1:0] A_CMP   = 56'h30_4000;
    localparam logic [AW-1:0] A_MTIME = 56'h30_bff8;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          cmd_v_i = 1'b0;
    logic          cmd_ready_o;
    logic          cmd_w_i = 1'b0;
    logic [AW-1:0] cmd_addr_i = '0;
    logic [63:0]   cmd_data_i = '0;
    logic          resp_v_o;
    logic          resp_yumi_i = 1'b0;
    logic [63:0]   resp_data_o;
    logic          resp_err_o;
    logic          software_irq_o;
    logic          timer_irq_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: mtime is the last written value plus the prescaler wraps seen since,
    // where wraps happen at the end of every cycle c with c % DIV == DIV-1.
    logic [63:0] m_base = 64'd0;
    int          m_from = 0;
    logic [63:0] m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    logic        m_mipi = 1'b0;
    bit          mon_en = 1'b0;

    bp_clint_slice #(.paddr_width_p(AW), .mtime_div_p(DIV)) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .cmd_v_i(cmd_v_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_w_i(cmd_w_i),
        .cmd_addr_i(cmd_addr_i),
        .cmd_data_i(cmd_data_i),
        .resp_v_o(resp_v_o),
        .resp_yumi_i(resp_yumi_i),
        .resp_data_o(resp_data_o),
        .resp_err_o(resp_err_o),
        .software_irq_o(software_irq_o),
        .timer_irq_o(timer_irq_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset_i) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    function automatic logic [63:0] modelMtime(input int c);
        return m_base + 64'((c / DIV) - (m_from / DIV));
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset_i) begin
            checkOutput("timer_irq", {63'd0, timer_irq_o}, {63'd0, modelMtime(cyc) >= m_cmp});
            checkOutput("software_irq", {63'd0, software_irq_o}, {63'd0, m_mipi});
        end
    end

    function automatic void modelReset();
        m_base = 64'd0;
        m_from = 0;
        m_cmp  = 64'hFFFF_FFFF_FFFF_FFFF;
        m_mipi = 1'b0;
    endfunction

    task automatic doReset();
        @(negedge clk);
        mon_en = 1'b0;
        reset_i = 1'b1;
        cmd_v_i = 1'b0;
        resp_yumi_i = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_cmd_ready", {63'd0, cmd_ready_o}, 64'd1);
        checkOutput("rst_resp_v", {63'd0, resp_v_o}, 64'd0);
        checkOutput("rst_resp_data", resp_data_o, 64'd0);
        checkOutput("rst_resp_err", {63'd0, resp_err_o}, 64'd0);
        checkOutput("rst_sw_irq", {63'd0, software_irq_o}, 64'd0);
        checkOutput("rst_timer_irq", {63'd0, timer_irq_o}, 64'd0);
        reset_i = 1'b0;
        modelReset();
        mon_en = 1'b1;
    endtask

    // Issues one command, checks the response against the model, and updates the model.
    task automatic applyStimulus(input bit w, input logic [AW-1:0] addr, input logic [63:0] data,
                                 input int yumi_delay, input bit align_wrap,
                                 output logic [63:0] rdata);
        int acc_cyc;
        logic [63:0] exp_data;
        logic exp_err;
        logic got_err;
        @(negedge clk);
        if (align_wrap) begin
            for (int i = 0; i < DIV + 1 && (cyc % DIV) != DIV - 1; i++) @(negedge clk);
        end
        checkOutput("cmd_ready_idle", {63'd0, cmd_ready_o}, 64'd1);
        cmd_v_i = 1'b1;
        cmd_w_i = w;
        cmd_addr_i = addr;
        cmd_data_i = data;
        acc_cyc = cyc;
        exp_err = !(addr == A_MIPI || addr == A_CMP || addr == A_MTIME);
        exp_data = 64'd0;
        if (!w) begin
            if (addr == A_MIPI)  exp_data = {63'd0, m_mipi};
            if (addr == A_CMP)   exp_data = m_cmp;
            if (addr == A_MTIME) exp_data = modelMtime(acc_cyc);
        end
        @(posedge clk);
        #1;
        cmd_v_i = 1'b0;
        if (w && addr == A_MIPI) m_mipi = data[0];
        if (w && addr == A_CMP)  m_cmp = data;
        if (w && addr == A_MTIME) begin
            m_base = data;
            m_from = acc_cyc + 1;
        end
        @(negedge clk);
        checkOutput("resp_v_latency", {63'd0, resp_v_o}, 64'd1);
        checkOutput("cmd_ready_busy", {63'd0, cmd_ready_o}, 64'd0);
        checkOutput("resp_data", resp_data_o, exp_data);
        checkOutput("resp_err", {63'd0, resp_err_o}, {63'd0, exp_err});
        rdata = resp_data_o;
        got_err = resp_err_o;
        for (int i = 0; i < yumi_delay; i++) begin
            @(negedge clk);
            checkOutput("hold_resp_v", {63'd0, resp_v_o}, 64'd1);
            checkOutput("hold_resp_data", resp_data_o, rdata);
            checkOutput("hold_resp_err", {63'd0, resp_err_o}, {63'd0, got_err});
        end
        resp_yumi_i = 1'b1;
        @(posedge clk);
        #1;
        resp_yumi_i = 1'b0;
        @(negedge clk);
        checkOutput("resp_v_drop", {63'd0, resp_v_o}, 64'd0);
        checkOutput("cmd_ready_back", {63'd0, cmd_ready_o}, 64'd1);
    endtask

    initial begin
        logic [63:0] rd;
        logic [63:0] held;
        int sel;
        logic [AW-1:0] addr;
        logic [63:0] wdata;

        doReset();

        // Idle to cycle 40 then read mtime.
        for (int i = 0; i < 100 && cyc < 39; i++) @(negedge clk);
        applyStimulus(1'b0, A_MTIME, 64'd0, 0, 1'b0, rd);
        checkOutput("mtime_after_40", rd, 64'd5);

        applyStimulus(1'b1, A_MIPI, 64'h3, 0, 1'b0, rd);
        applyStimulus(1'b0, A_MIPI, 64'd0, 1, 1'b0, rd);
        checkOutput("mipi_readback", rd, 64'h1);
        applyStimulus(1'b1, A_MIPI, 64'h0, 0, 1'b0, rd);

        applyStimulus(1'b1, A_MTIME, 64'd3, 0, 1'b0, rd);
        applyStimulus(1'b1, A_CMP, 64'd10, 0, 1'b0, rd);
        for (int i = 0; i < 300 && !timer_irq_o; i++) @(negedge clk);
        checkOutput("timer_rise", {63'd0, timer_irq_o}, 64'd1);
        checkOutput("timer_rise_mtime", modelMtime(cyc), 64'd10);
        applyStimulus(1'b1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, rd);
        @(negedge clk);
        checkOutput("timer_fall", {63'd0, timer_irq_o}, 64'd0);

        applyStimulus(1'b1, A_MTIME, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, rd);
        repeat (8) @(negedge clk);
        applyStimulus(1'b0, A_MTIME, 64'd0, 0, 1'b0, rd);
        applyStimulus(1'b1, A_MTIME, 64'h1234, 0, 1'b1, rd);
        applyStimulus(1'b0, A_MTIME, 64'd0, 0, 1'b0, rd);
        checkOutput("mtime_write_wins", rd, 64'h1234);

        applyStimulus(1'b0, 56'h30_1000, 64'd0, 0, 1'b0, rd);
        applyStimulus(1'b0, 56'h30_4004, 64'd0, 0, 1'b0, rd);
        applyStimulus(1'b1, 56'h30_2000, 64'h1, 0, 1'b0, rd);
        applyStimulus(1'b0, A_CMP, 64'd0, 0, 1'b0, rd);
        applyStimulus(1'b0, A_MIPI, 64'd0, 0, 1'b0, rd);

        // Stall with a new command pending; it must not be taken while busy.
        @(negedge clk);
        cmd_v_i = 1'b1;
        cmd_w_i = 1'b0;
        cmd_addr_i = A_CMP;
        @(posedge clk);
        #1;
        cmd_w_i = 1'b1;
        cmd_addr_i = A_MIPI;
        cmd_data_i = 64'h1;
        @(negedge clk);
        held = resp_data_o;
        checkOutput("stall_data", held, m_cmp);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_cmd_ready", {63'd0, cmd_ready_o}, 64'd0);
            checkOutput("stall_resp_v", {63'd0, resp_v_o}, 64'd1);
            checkOutput("stall_resp_data", resp_data_o, held);
            @(negedge clk);
        end
        cmd_v_i = 1'b0;
        resp_yumi_i = 1'b1;
        @(posedge clk);
        #1;
        resp_yumi_i = 1'b0;

        // Reset while a response is pending.
        applyStimulus(1'b1, A_CMP, 64'd5, 0, 1'b0, rd);
        @(negedge clk);
        cmd_v_i = 1'b1;
        cmd_w_i = 1'b0;
        cmd_addr_i = A_MTIME;
        @(posedge clk);
        #1;
        cmd_v_i = 1'b0;
        @(negedge clk);
        checkOutput("pre_reset_resp_v", {63'd0, resp_v_o}, 64'd1);
        mon_en = 1'b0;
        reset_i = 1'b1;
        @(negedge clk);
        checkOutput("reset_drops_resp_v", {63'd0, resp_v_o}, 64'd0);
        reset_i = 1'b0;
        modelReset();
        mon_en = 1'b1;
        applyStimulus(1'b0, A_CMP, 64'd0, 0, 1'b0, rd);
        checkOutput("cmp_after_reset", rd, 64'hFFFF_FFFF_FFFF_FFFF);

        // Random traffic.
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0:       addr = A_MIPI;
                1, 2:    addr = A_CMP;
                3:       addr = A_MTIME;
                4:       addr = 56'h30_0000 + AW'($urandom_range(1, 4095) * 8);
                default: addr = A_CMP | AW'($urandom_range(1, 7));
            endcase
            wdata = {$urandom(), $urandom()};
            if (addr == A_CMP && $urandom_range(0, 3) != 0)
                wdata = modelMtime(cyc) + 64'($urandom_range(0, 12));
            if (addr == A_MTIME && $urandom_range(0, 1) == 1)
                wdata = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
            applyStimulus(1'($urandom_range(0, 1)), addr, wdata, $urandom_range(0, 3),
                          1'($urandom_range(0, 3) == 0), rd);
            repeat ($urandom_range(0, 10)) @(negedge clk);
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
